// File: rtl/oled_ctrl_pkg.sv
// Shared types and constants for the OLED power-up/refresh sequencer.
// Holds FSM encodings, SPI word prefixes and page-addressing commands.
package oled_ctrl_pkg;

  localparam int RES_LOW_CYCLES  = 500;
  localparam int RES_WAIT_CYCLES = 5000;
  localparam int INIT_LEN        = 25;
  localparam int PAGES           = 8;
  localparam int COLS            = 128;

  localparam int DLY_MAX = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ?
                           RES_LOW_CYCLES : RES_WAIT_CYCLES;
  localparam int DLY_W   = $clog2(DLY_MAX);

  typedef enum logic [2:0] {
    S_RES_LOW,
    S_RES_WAIT,
    S_SEND,
    S_ACK,
    S_GAP,
    S_FETCH,
    S_FB_WAIT,
    S_IDLE
  } state_e;

  // What the controller is streaming; picks the next word after a GAP.
  typedef enum logic [1:0] {
    PH_INIT,
    PH_PGCMD,
    PH_DATA,
    PH_END
  } phase_e;

  localparam logic [1:0] PFX_CMD  = 2'b00;
  localparam logic [1:0] PFX_DAT  = 2'b01;
  localparam logic [9:0] SPI_IDLE = 10'h200;

  localparam logic [7:0] CMD_PAGE   = 8'hB0;
  localparam logic [7:0] CMD_COL_LO = 8'h00;
  localparam logic [7:0] CMD_COL_HI = 8'h10;

  // Three-command page header: page select, column low, column high.
  function automatic logic [7:0] pg_cmd(input logic [1:0] sub,
                                        input logic [2:0] page);
    logic [7:0] c;
    c = CMD_COL_HI;
    case (sub)
      2'd0:    c = CMD_PAGE | {5'd0, page};
      2'd1:    c = CMD_COL_LO;
      default: c = CMD_COL_HI;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/oled_ctrl_init_rom.sv
// Fixed SSD1306 init command list.
// Combinational lookup indexed by the init step counter.
module oled_init_rom
  import oled_ctrl_pkg::*;
(
  input  logic [4:0] idx_i,
  output logic [7:0] cmd_o
);

  // Command table in transmit order.
  always_comb begin
    cmd_o = 8'hAE;
    case (idx_i)
      5'd0:    cmd_o = 8'hAE;
      5'd1:    cmd_o = 8'hD5;
      5'd2:    cmd_o = 8'h80;
      5'd3:    cmd_o = 8'hA8;
      5'd4:    cmd_o = 8'h3F;
      5'd5:    cmd_o = 8'hD3;
      5'd6:    cmd_o = 8'h00;
      5'd7:    cmd_o = 8'h40;
      5'd8:    cmd_o = 8'h8D;
      5'd9:    cmd_o = 8'h14;
      5'd10:   cmd_o = 8'h20;
      5'd11:   cmd_o = 8'h02;
      5'd12:   cmd_o = 8'hA1;
      5'd13:   cmd_o = 8'hC8;
      5'd14:   cmd_o = 8'hDA;
      5'd15:   cmd_o = 8'h12;
      5'd16:   cmd_o = 8'h81;
      5'd17:   cmd_o = 8'hCF;
      5'd18:   cmd_o = 8'hD9;
      5'd19:   cmd_o = 8'hF1;
      5'd20:   cmd_o = 8'hDB;
      5'd21:   cmd_o = 8'h40;
      5'd22:   cmd_o = 8'hA4;
      5'd23:   cmd_o = 8'hA6;
      5'd24:   cmd_o = 8'hAF;
      default: cmd_o = 8'hAE;
    endcase
  end

endmodule

// File: rtl/oled_ctrl.sv
// OLED power-up and frame refresh sequencer.
// Owns the SPI byte writer handshake; streams init list and framebuffer.
module oled_ctrl
  import oled_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       REFRESH,
  output logic [9:0] FB_ADDR,
  input  logic [7:0] FB_DATA,
  output logic       SPI_START,
  output logic [9:0] SPI_DATA,
  input  logic       SPI_DONE,
  output logic       OLED_RES,
  output logic       READY,
  output logic       BUSY
);

  state_e           state_q;
  phase_e           phase_q;
  logic [DLY_W-1:0] cnt_q;
  logic [4:0]       idx_q;
  logic [2:0]       page_q;
  logic [6:0]       col_q;
  logic [1:0]       sub_q;
  logic             pending_q;
  logic             start_q;
  logic [9:0]       data_q;
  logic [9:0]       addr_q;
  logic             res_q;
  logic             ready_q;
  logic             busy_q;
  logic [7:0]       rom_cmd;

  oled_init_rom u_rom (
    .idx_i (idx_q),
    .cmd_o (rom_cmd)
  );

  // Sequencer: reset pulse, init list, page headers, data, handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_RES_LOW;
      phase_q   <= PH_INIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      page_q    <= '0;
      col_q     <= '0;
      sub_q     <= '0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= SPI_IDLE;
      addr_q    <= '0;
      res_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (REFRESH && state_q != S_IDLE)
        pending_q <= 1'b1;
      case (state_q)
        S_RES_LOW: begin
          busy_q <= 1'b1;
          if (cnt_q == DLY_W'(RES_LOW_CYCLES - 1)) begin
            cnt_q   <= '0;
            res_q   <= 1'b1;
            state_q <= S_RES_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RES_WAIT: begin
          if (cnt_q == DLY_W'(RES_WAIT_CYCLES - 1)) begin
            cnt_q   <= '0;
            phase_q <= PH_INIT;
            data_q  <= {PFX_CMD, rom_cmd};
            start_q <= 1'b1;
            state_q <= S_SEND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SEND: begin
          if (SPI_DONE)
            state_q <= S_ACK;
        end
        S_ACK: begin
          start_q <= 1'b0;
          state_q <= S_GAP;
          unique case (phase_q)
            PH_INIT: begin
              idx_q <= idx_q + 1'b1;
              if (idx_q == 5'(INIT_LEN - 1)) begin
                ready_q <= 1'b1;
                page_q  <= '0;
                sub_q   <= '0;
                phase_q <= PH_PGCMD;
              end
            end
            PH_PGCMD: begin
              if (sub_q == 2'd2) begin
                sub_q   <= '0;
                col_q   <= '0;
                phase_q <= PH_DATA;
              end else begin
                sub_q <= sub_q + 1'b1;
              end
            end
            PH_DATA: begin
              if (col_q == 7'(COLS - 1)) begin
                col_q <= '0;
                if (page_q == 3'(PAGES - 1)) begin
                  page_q  <= '0;
                  phase_q <= PH_END;
                end else begin
                  page_q  <= page_q + 1'b1;
                  phase_q <= PH_PGCMD;
                end
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
            PH_END: ;
          endcase
        end
        S_GAP: begin
          unique case (phase_q)
            PH_INIT: begin
              data_q  <= {PFX_CMD, rom_cmd};
              start_q <= 1'b1;
              state_q <= S_SEND;
            end
            PH_PGCMD: begin
              data_q  <= {PFX_CMD, pg_cmd(sub_q, page_q)};
              start_q <= 1'b1;
              state_q <= S_SEND;
            end
            PH_DATA: begin
              addr_q  <= {page_q, col_q};
              state_q <= S_FETCH;
            end
            PH_END: begin
              if (pending_q) begin
                pending_q <= 1'b0;
                phase_q   <= PH_PGCMD;
                data_q    <= {PFX_CMD, CMD_PAGE};
                start_q   <= 1'b1;
                state_q   <= S_SEND;
              end else begin
                busy_q  <= 1'b0;
                data_q  <= SPI_IDLE;
                state_q <= S_IDLE;
              end
            end
          endcase
        end
        S_FETCH: begin
          state_q <= S_FB_WAIT;
        end
        S_FB_WAIT: begin
          data_q  <= {PFX_DAT, FB_DATA};
          start_q <= 1'b1;
          state_q <= S_SEND;
        end
        S_IDLE: begin
          if (REFRESH || pending_q) begin
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
            phase_q   <= PH_PGCMD;
            data_q    <= {PFX_CMD, CMD_PAGE};
            start_q   <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        default: state_q <= S_RES_LOW;
      endcase
    end
  end

  assign FB_ADDR   = addr_q;
  assign SPI_START = start_q;
  assign SPI_DATA  = data_q;
  assign OLED_RES  = res_q;
  assign READY     = ready_q;
  assign BUSY      = busy_q;

endmodule
